// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: CPU data-memory responder with a word RAM and an MMIO
// page (LED, free-running cycle counter, compare timer with pending flag).
//
// Ports:
//   sys_clk   : system clock, all state updates on the rising edge
//   sys_rst   : synchronous active-high reset (MMIO state only, RAM kept)
//   daddr     : byte address from the CPU, [1:0] ignored (word access)
//   din       : write data from the CPU
//   MemWrite  : write strobe, same cycle as daddr/din
//   dout      : combinational read data for daddr
//   led       : LED register
//   timer_irq : timer pending flag (level)
//   bus_err   : sticky out-of-range flag
//
// Build option: define DMEM_BOUNDS_TRAP_EN to trap RAM accesses beyond
// DEPTH_WORDS (blocked write, 32'hDEADBEEF read, sticky bus_err).
// Without it upper address bits alias into the RAM and bus_err is 0.
module dmem_mmio_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [31:0] daddr,
   input  logic [31:0] din,
   input  logic        MemWrite,
   output logic [31:0] dout,
   output logic [15:0] led,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   localparam logic [7:0] OFF_LED   = 8'h00;
   localparam logic [7:0] OFF_CYCLE = 8'h04;
   localparam logic [7:0] OFF_TCMP  = 8'h08;
   localparam logic [7:0] OFF_TCTRL = 8'h0C;
   localparam logic [7:0] OFF_TCNT  = 8'h10;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic          is_mmio;
   logic [7:0]    off;
   logic [AW-1:0] idx;
   logic          oob;
   logic          ram_we;
   logic          mmio_we;

   logic sel_led;
   logic sel_cycle;
   logic sel_tcmp;
   logic sel_tctrl;
   logic sel_tcnt;

   assign is_mmio = (daddr[31:16] == MMIO_HI);
   assign off     = daddr[7:0];
   assign idx     = daddr[AW+1:2];

`ifdef DMEM_BOUNDS_TRAP_EN
   assign oob = !is_mmio && (daddr[31:AW+2] != '0);
`else
   assign oob = 1'b0;
`endif

   assign ram_we  = MemWrite && !is_mmio && !oob;
   assign mmio_we = MemWrite && is_mmio;

   assign sel_led   = (off == OFF_LED);
   assign sel_cycle = (off == OFF_CYCLE);
   assign sel_tcmp  = (off == OFF_TCMP);
   assign sel_tctrl = (off == OFF_TCTRL);
   assign sel_tcnt  = (off == OFF_TCNT);

   // Which address bits are consumed depends on DEPTH_WORDS and the
   // build option; fold the whole bus here so none are flagged unused.
   logic unused_daddr;
   assign unused_daddr = ^daddr;

   // ------------------------------------------------------------------
   // Data RAM: synchronous write, asynchronous read, never reset.
   // A read in the write cycle sees the old word.
   // ------------------------------------------------------------------
   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge sys_clk) begin
      if (ram_we) begin
         mem[idx] <= din;
      end
   end

   // ------------------------------------------------------------------
   // MMIO registers
   // ------------------------------------------------------------------
   logic [15:0] led_q;
   logic [31:0] cycle_q;
   logic [31:0] tcmp_q;
   logic [31:0] tcnt_q;
   logic        en_q;
   logic        auto_q;
   logic        pend_q;

   logic [15:0] led_d;
   logic [31:0] cycle_d;
   logic [31:0] tcmp_d;
   logic [31:0] tcnt_d;
   logic        en_d;
   logic        auto_d;
   logic        pend_d;
   logic        pend_set;
   logic        pend_clr;

   // Timer first, CPU write second: the write overrides TCNT/EN/AUTO,
   // but the match itself was judged on the registered values.
   always_comb begin
      led_d    = led_q;
      cycle_d  = cycle_q + 32'd1;
      tcmp_d   = tcmp_q;
      tcnt_d   = tcnt_q;
      en_d     = en_q;
      auto_d   = auto_q;
      pend_set = 1'b0;
      pend_clr = 1'b0;

      if (en_q) begin
         if (tcnt_q == tcmp_q) begin
            pend_set = 1'b1;
            if (auto_q) begin
               tcnt_d = '0;
            end else begin
               en_d = 1'b0;
            end
         end else begin
            tcnt_d = tcnt_q + 32'd1;
         end
      end

      if (mmio_we) begin
         unique case (1'b1)
            sel_led: begin
               led_d = din[15:0];
            end
            sel_tcmp: begin
               tcmp_d = din;
            end
            sel_tctrl: begin
               en_d     = din[0];
               pend_clr = din[1];
               auto_d   = din[2];
            end
            sel_tcnt: begin
               tcnt_d = din;
            end
            default: begin
            end
         endcase
      end

      // A match in the same cycle wins over a W1C clear.
      pend_d = pend_set | (pend_q & ~pend_clr);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         led_q   <= '0;
         cycle_q <= '0;
         tcmp_q  <= '1;
         tcnt_q  <= '0;
         en_q    <= 1'b0;
         auto_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         led_q   <= led_d;
         cycle_q <= cycle_d;
         tcmp_q  <= tcmp_d;
         tcnt_q  <= tcnt_d;
         en_q    <= en_d;
         auto_q  <= auto_d;
         pend_q  <= pend_d;
      end
   end

   // ------------------------------------------------------------------
   // Bounds trap
   // ------------------------------------------------------------------
`ifdef DMEM_BOUNDS_TRAP_EN
   logic berr_q;

   // Any out-of-range address sets it, read or write.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         berr_q <= 1'b0;
      end else begin
         berr_q <= berr_q | oob;
      end
   end

   assign bus_err = berr_q;
`else
   assign bus_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read mux (values before the current edge)
   // ------------------------------------------------------------------
   always_comb begin
      dout = '0;
      if (!is_mmio) begin
         dout = oob ? 32'hDEAD_BEEF : mem[idx];
      end else begin
         unique case (1'b1)
            sel_led:   dout = {16'h0, led_q};
            sel_cycle: dout = cycle_q;
            sel_tcmp:  dout = tcmp_q;
            sel_tctrl: dout = {29'h0, auto_q, pend_q, en_q};
            sel_tcnt:  dout = tcnt_q;
            default:   dout = '0;
         endcase
      end
   end

   assign led       = led_q;
   assign timer_irq = pend_q;

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the CPU data-memory interface: receives daddr/din/MemWrite and returns dout in the same cycle, as the single-cycle core requires.
- Decodes each access to one of two regions: a word-addressed data RAM, or a memory-mapped I/O page.
- The MMIO page holds an LED register, a free-running cycle counter and a compare timer with an interrupt flag.
- Sits beside the CPU in the top level, replacing a bare data_ram.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must be a power of two.
- MMIO_HI, 16'hFFFF: value of daddr[31:16] that selects the MMIO page.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- daddr  in  32  byte address from the CPU (ALU result).
- din  in  32  write data from the CPU.
- MemWrite  in  1  write strobe, valid in the same cycle as daddr/din.
- dout  out  32  read data to the CPU; combinational from daddr.
- led  out  16  LED register value.
- timer_irq  out  1  timer pending flag (level).
- bus_err  out  1  sticky out-of-range flag; tied to 0 unless the optional feature is enabled.

Behaviour:
- Region decode:
  - MMIO when daddr[31:16]==MMIO_HI.
  - Otherwise RAM, with index = daddr[log2(DEPTH_WORDS)+1:2].
  - daddr[1:0] is ignored in both regions (word access only).
- RAM:
  - Write at the rising edge when MemWrite=1 and the RAM region is selected.
  - Read is combinational: dout=mem[index].
  - Read-during-write to the same word returns the old data; the new data is visible from the next cycle.
  - Reset does not clear RAM.
- MMIO registers, selected by daddr[7:0]; reset values in brackets:
  - 0x00 LED, RW, bits[15:0] [0]. Reads return zero-extended; write uses din[15:0].
  - 0x04 CYCLE, RO [0]. +1 every cycle after reset; wraps 0xFFFFFFFF→0; writes ignored.
  - 0x08 TCMP, RW [0xFFFFFFFF].
  - 0x0C TCTRL [0]:
    - bit0 EN, RW.
    - bit1 PEND: reads the flag; writing 1 clears it (W1C).
    - bit2 AUTO, RW.
    - Other bits read 0.
  - 0x10 TCNT, RW [0].
  - Any other offset: reads 0, writes ignored.
- Timer, evaluated each edge with EN=1:
  - If TCNT==TCMP: set PEND. Then either TCNT←0 (AUTO=1), or TCNT holds and EN←0 (AUTO=0, one-shot).
  - Otherwise: TCNT←TCNT+1; it wraps at 2^32.
  - With EN=0, TCNT holds.
- Priority in the same cycle:
  - A CPU write to TCNT overrides increment/reload.
  - A CPU write to TCTRL sets EN/AUTO; the match logic uses the pre-write register values.
  - PEND set by a match beats a W1C clear in the same cycle.
- Output timing:
  - timer_irq = PEND (registered); it rises the cycle after the match edge is evaluated.
  - led is driven directly from the LED register.
- sys_rst=1 at any edge:
  - All MMIO registers and bus_err return to their reset values.
  - Any in-progress timer count is discarded.
  - A write presented in the same cycle is dropped for MMIO but still applies to RAM.
- dout for MMIO reads reflects register values before the current edge.

Optional Feature:
- Macro: DMEM_BOUNDS_TRAP_EN.
- Defined:
  - A RAM-region access with any of daddr[31:log2(DEPTH_WORDS)+2] nonzero is out-of-range.
  - Out-of-range writes are blocked.
  - Out-of-range reads return 32'hDEADBEEF.
  - bus_err is set at the edge and stays 1 until sys_rst. MemWrite is not required to set it: any out-of-range daddr sets it.
- Undefined:
  - Upper address bits alias (wrap) into the RAM.
  - bus_err is constant 0.

Test Plan:
1. Reset, then write 0x12345678 to 0x00000010, then read 0x00000010 → dout=0x12345678. Read 0x00000012 → the same value (byte offset ignored).
2. Reset; read 0xFFFF0004 at cycles 1 and 6 → the values differ by exactly 5. Write 0 to 0xFFFF0004 → the count is unaffected.
3. Write TCMP=3, then TCTRL=0x5 (EN|AUTO):
   - TCNT sequence 0,1,2,3,0,…
   - timer_irq goes 1 the cycle after TCNT=3 is matched.
   - Write TCTRL=0x7 → PEND clears; EN/AUTO stay 1.
4. One-shot: TCMP=2, TCTRL=0x1 → after the match, EN reads 0, TCNT stays 2, PEND=1. In the same cycle as a match, write TCTRL bit1 → PEND stays 1 (set wins).
5. Write LED=0xABCD1234 → led=0x1234; reading 0xFFFF0000 gives 0x00001234. Assert sys_rst → led=0, CYCLE=0, TCMP=0xFFFFFFFF. Re-read of the RAM word from test 1 → still 0x12345678.
6. DEPTH_WORDS=1024, write 0xCAFEF00D to 0x00001010:
   - With DMEM_BOUNDS_TRAP_EN: bus_err=1 and stays 1; RAM[4] is unchanged; the read returns 0xDEADBEEF.
   - Without the macro: RAM[4]=0xCAFEF00D and bus_err=0.
